// File: rtl/bitcount_feeder.sv
// Feeds 32-bit words from a small FIFO into a bitcount block and returns word/count pairs with a running total.
// Optional launch timeout and sticky timeout_err output when BITCOUNT_FEEDER_TIMEOUT_EN is defined.
module bitcount_feeder #(
    parameter int unsigned DEPTH = 4
`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bc_start,
    output logic [31:0] bc_in,
    input  logic        bc_finish,
    input  logic [31:0] bc_count,
    output logic [31:0] res_word,
    output logic [31:0] res_count,
    output logic        res_valid,
    input  logic        res_ready,
    input  logic        clear_total,
    output logic [31:0] total,
`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RELEASE,
        ST_OUTPUT
    } state_e;

    state_e          state_q, state_d;
    logic            rel_first_q, rel_first_d;
    logic            bc_start_q, bc_start_d;
    logic [DW-1:0]   bc_in_q, bc_in_d;
    logic            res_valid_q, res_valid_d;
    logic [DW-1:0]   res_word_q, res_word_d;
    logic [DW-1:0]   res_count_q, res_count_d;
    logic [DW-1:0]   total_q, total_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;

    logic            push;
    logic            pop;
    logic            accept;

`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]   timer_q, timer_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Next-state, FIFO bookkeeping and result/total datapath.
    always_comb begin
        state_d     = state_q;
        rel_first_d = 1'b0;
        bc_start_d  = bc_start_q;
        bc_in_d     = bc_in_q;
        res_valid_d = res_valid_q;
        res_word_d  = res_word_q;
        res_count_d = res_count_q;
        push        = in_valid && !full_q;
        pop         = 1'b0;
        accept      = res_valid_q && res_ready;
`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
        timer_d       = (state_q == ST_LAUNCH) ? timer_q + TW'(1) : '0;
        timeout_err_d = timeout_err_q;
`endif

        if (accept) begin
            res_valid_d = 1'b0;
        end
        // Clear wins first so a same-cycle acceptance still lands in the total.
        total_d = clear_total ? '0 : total_q;
        if (accept) begin
            total_d = total_d + res_count_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    bc_in_d    = mem_q[rd_ptr_q];
                    bc_start_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (bc_finish) begin
                    res_count_d = bc_count;
                    res_word_d  = bc_in_q;
                    res_valid_d = 1'b1;
                    bc_start_d  = 1'b0;
                    rel_first_d = 1'b1;
                    state_d     = ST_RELEASE;
                end
`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    bc_start_d    = 1'b0;
                    rel_first_d   = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                // First cycle always held so start stays low long enough between jobs.
                if (!rel_first_q && !bc_finish) begin
                    state_d = res_valid_d ? ST_OUTPUT : ST_IDLE;
                end
            end
            ST_OUTPUT: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(DEPTH));
        busy_d   = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rel_first_q <= 1'b0;
            bc_start_q  <= 1'b0;
            bc_in_q     <= '0;
            res_valid_q <= 1'b0;
            res_word_q  <= '0;
            res_count_q <= '0;
            total_q     <= '0;
            busy_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rel_first_q <= rel_first_d;
            bc_start_q  <= bc_start_d;
            bc_in_q     <= bc_in_d;
            res_valid_q <= res_valid_d;
            res_word_q  <= res_word_d;
            res_count_q <= res_count_d;
            total_q     <= total_d;
            busy_q      <= busy_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign in_ready  = !full_q;
    assign bc_start  = bc_start_q;
    assign bc_in     = bc_in_q;
    assign res_valid = res_valid_q;
    assign res_word  = res_word_q;
    assign res_count = res_count_q;
    assign total     = total_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bitcount_feeder.sv
// Directed self-checking bench for bitcount_feeder with a level-protocol bitcount responder.
// Exercises the timeout path too when BITCOUNT_FEEDER_TIMEOUT_EN is defined.
module tb_bitcount_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bc_start;
    logic [31:0] bc_in;
    logic        bc_finish = 1'b0;
    logic [31:0] bc_count = 32'd0;
    logic [31:0] res_word;
    logic [31:0] res_count;
    logic        res_valid;
    logic        res_ready;
    logic        clear_total;
    logic [31:0] total;
    logic        busy;
`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
    logic        timeout_err;
`endif

    logic        stub_en = 1'b1;
    int          checks = 0;
    int          errors = 0;

    bitcount_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bc_start    (bc_start),
        .bc_in       (bc_in),
        .bc_finish   (bc_finish),
        .bc_count    (bc_count),
        .res_word    (res_word),
        .res_count   (res_count),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .clear_total (clear_total),
        .total       (total),
`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Bitcount stand-in: answers one negedge after start rises, drops finish once start falls.
    always @(negedge clk) begin
        if (stub_en && bc_start && !bc_finish) begin
            bc_finish = 1'b1;
            bc_count  = 32'($countones(bc_in));
        end else if (!bc_start && bc_finish) begin
            bc_finish = 1'b0;
        end
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 40) begin
            tick(1);
            n++;
        end
        chk1(tag, res_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] burst [5];
        logic [31:0] bcnt  [5];
        int          idx;
        int          cyc;
        logic        hs;

        burst[0] = 32'h0000_0000; bcnt[0] = 32'd0;
        burst[1] = 32'h8000_0000; bcnt[1] = 32'd1;
        burst[2] = 32'hFFFF_FFFF; bcnt[2] = 32'd32;
        burst[3] = 32'hFF00_FF00; bcnt[3] = 32'd16;
        burst[4] = 32'h00FF_00FF; bcnt[4] = 32'd16;

        // Reset held with in_valid asserted.
        rst         = 1'b0;
        in_valid    = 1'b1;
        in_data     = 32'h1234_5678;
        res_ready   = 1'b0;
        clear_total = 1'b0;
        tick(2);
        chk1 ("rst_in_ready",  in_ready,  1'b1);
        chk1 ("rst_bc_start",  bc_start,  1'b0);
        chk32("rst_bc_in",     bc_in,     32'h0);
        chk1 ("rst_res_valid", res_valid, 1'b0);
        chk32("rst_res_word",  res_word,  32'h0);
        chk32("rst_res_count", res_count, 32'h0);
        chk32("rst_total",     total,     32'h0);
        chk1 ("rst_busy",      busy,      1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        tick(1);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_busy",     busy,     1'b0);

        // Single word, timed latency.
        res_ready = 1'b1;
        in_data   = 32'h8000_0800;
        in_valid  = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk1("b_start_lo", bc_start, 1'b0);
        chk1("b_busy",     busy,     1'b1);
        tick(1);
        chk1 ("b_start_hi", bc_start, 1'b1);
        chk32("b_bc_in",    bc_in,    32'h8000_0800);
        tick(1);
        chk1 ("b_res_valid", res_valid, 1'b1);
        chk32("b_res_count", res_count, 32'd2);
        chk32("b_res_word",  res_word,  32'h8000_0800);
        chk1 ("b_start_drop", bc_start, 1'b0);
        tick(1);
        chk32("b_total",     total,     32'd2);
        chk1 ("b_res_taken", res_valid, 1'b0);
        tick(3);
        chk1("b_idle", busy, 1'b0);

        // Burst into a stalled consumer.
        res_ready   = 1'b0;
        clear_total = 1'b1;
        tick(1);
        clear_total = 1'b0;
        chk32("c_clear_only", total, 32'd0);
        idx      = 0;
        cyc      = 0;
        in_valid = 1'b1;
        in_data  = burst[0];
        while (idx < 5 && cyc < 50) begin
            hs = in_ready;
            tick(1);
            cyc++;
            if (hs) begin
                idx++;
                if (idx < 5) in_data = burst[idx];
            end
        end
        in_valid = 1'b0;
        chk32("c_accepted", 32'(idx), 32'd5);
        chk1 ("c_full",     in_ready, 1'b0);
        tick(3);
        chk1 ("c_full_hold", in_ready, 1'b0);
        wait_res("c_first_valid");
        tick(2);
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_res("c_res_valid");
            chk32("c_res_word",  res_word,  burst[k]);
            chk32("c_res_count", res_count, bcnt[k]);
            tick(1);
        end
        chk32("c_total",    total,    32'd65);
        chk1 ("c_drained",  in_ready, 1'b1);

        // Backpressure for 10 cycles with a second word queued.
        res_ready   = 1'b0;
        clear_total = 1'b1;
        tick(1);
        clear_total = 1'b0;
        chk32("d_cleared", total, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        tick(1);
        in_data  = 32'hFF00_0000;
        tick(1);
        in_valid = 1'b0;
        wait_res("d_valid");
        chk32("d_word",  res_word,  32'hFFFF_FFFF);
        chk32("d_count", res_count, 32'd32);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk1 ("d_hold_valid", res_valid, 1'b1);
            chk32("d_hold_word",  res_word,  32'hFFFF_FFFF);
            chk32("d_hold_count", res_count, 32'd32);
            chk1 ("d_no_start",   bc_start,  1'b0);
            chk32("d_hold_total", total,     32'd0);
        end
        res_ready = 1'b1;
        tick(1);
        chk32("d_total_32",    total,    32'd32);
        chk1 ("d_start_wait",  bc_start, 1'b0);
        tick(1);
        chk1 ("d_start_resume", bc_start, 1'b1);
        chk32("d_bc_in",        bc_in,    32'hFF00_0000);
        wait_res("d_valid2");
        chk32("d_count2", res_count, 32'd8);
        tick(1);
        chk32("d_total_40", total, 32'd40);

        // Clear coinciding with acceptance.
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h8408_0804;
        tick(1);
        in_valid = 1'b0;
        wait_res("e_valid");
        chk32("e_count",     res_count, 32'd5);
        chk32("e_pre_total", total,     32'd40);
        res_ready   = 1'b1;
        clear_total = 1'b1;
        tick(1);
        clear_total = 1'b0;
        chk32("e_total", total,     32'd5);
        chk1 ("e_taken", res_valid, 1'b0);

        // Asynchronous reset in the middle of a launch.
        tick(4);
        stub_en  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0000_000F;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        chk1("f_start_hi", bc_start, 1'b1);
        tick(3);
        #2;
        rst = 1'b0;
        #1;
        chk1 ("f_start_async", bc_start,  1'b0);
        chk1 ("f_no_res",      res_valid, 1'b0);
        chk1 ("f_in_ready",    in_ready,  1'b1);
        chk32("f_bc_in",       bc_in,     32'h0);
        chk32("f_total",       total,     32'h0);
        tick(1);
        rst     = 1'b1;
        stub_en = 1'b1;
        tick(4);
        chk1("f_no_res_after", res_valid, 1'b0);
        chk1("f_empty",        busy,      1'b0);
        chk1("f_no_relaunch",  bc_start,  1'b0);

`ifdef BITCOUNT_FEEDER_TIMEOUT_EN
        // Launch that never finishes.
        stub_en  = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        tick(1);
        in_valid = 1'b0;
        tick(30);
        chk1("g_no_timeout_yet", timeout_err, 1'b0);
        tick(40);
        chk1("g_timeout",   timeout_err, 1'b1);
        chk1("g_no_res",    res_valid,   1'b0);
        chk1("g_start_low", bc_start,    1'b0);
        stub_en   = 1'b1;
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0003;
        tick(1);
        in_valid = 1'b0;
        wait_res("g_next_valid");
        chk32("g_next_count", res_count, 32'd2);
        chk32("g_next_word",  res_word,  32'h0000_0003);
        tick(1);
        chk1("g_sticky", timeout_err, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
